alu_muldiv: RTL

- Parametrised next-generation ALU for the multi-cycle MIPS datapath.
- Keeps the single-cycle integer ops combinational.
- Adds a sequential multiply/divide unit with architectural HI/LO registers and MFHI/MFLO/MTHI/MTLO.
- Sits in EX; the control unit stalls on in_ready=0.

---
 rtl/alu_muldiv_pkg.sv | 41 ++++
 rtl/alu_muldiv_muldiv.sv | 138 +++++++++++++
 rtl/alu_muldiv.sv | 70 +++++++
 3 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared decode header: ALU op codes and mul/div sequencer state encodings.
// Latency: n/a (constants and a pure helper only).
// Backpressure: n/a.
package alu_muldiv_pkg;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_OR    = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_SLLV  = 5'd11;
  localparam logic [4:0] OP_SRLV  = 5'd12;
  localparam logic [4:0] OP_SRAV  = 5'd13;
  localparam logic [4:0] OP_LUI   = 5'd14;
  localparam logic [4:0] OP_MFHI  = 5'd15;
  localparam logic [4:0] OP_MFLO  = 5'd16;
  localparam logic [4:0] OP_MULT  = 5'd17;
  localparam logic [4:0] OP_MULTU = 5'd18;
  localparam logic [4:0] OP_DIV   = 5'd19;
  localparam logic [4:0] OP_DIVU  = 5'd20;
  localparam logic [4:0] OP_MTHI  = 5'd21;
  localparam logic [4:0] OP_MTLO  = 5'd22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  // True for the ops that launch the multi-cycle multiply/divide sequence.
  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_muldiv.sv
// Sequential multiply/divide unit owning the architectural HI/LO registers.
// Latency: MTHI/MTLO one edge; MULT/DIV results land WIDTH+1 edges after accept.
// Backpressure: in_ready low while RUN/FIX; any op presented then is not taken.
module muldiv_seq
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t          state_q, state_d;
  logic [SHW-1:0]     cnt_q;
  // Multiply: {upper partial, multiplier}; divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opd_q;     // multiplicand or divisor magnitude
  logic               is_div_q;
  logic               neg_q;     // product sign or quotient sign
  logic               rneg_q;    // remainder sign (dividend sign)
  logic               dz_q;      // divide by zero

  logic               idle;
  logic               xfer;
  logic               start_md;
  logic               is_signed;
  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   quo_mag, rem_mag, quo_fix, rem_fix;

  assign idle      = (state_q == ST_IDLE);
  assign xfer      = in_valid & idle;
  assign start_md  = xfer & is_muldiv(op);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign sgn_a     = is_signed & a[WIDTH-1];
  assign sgn_b     = is_signed & b[WIDTH-1];
  assign mag_a     = sgn_a ? -a : a;
  assign mag_b     = sgn_b ? -b : b;

  // One shift-add step: add multiplicand to the upper half when the multiplier LSB is set.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opd_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring step: trial-subtract the divisor from {remainder, next dividend bit}.
  assign div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opd_q};
  assign div_next = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Sign correction applied in FIX; MIN/-1 falls out naturally as lo=MIN, hi=0.
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_mag  = acc_q[WIDTH-1:0];
  assign rem_mag  = acc_q[2*WIDTH-1:WIDTH];
  assign quo_fix  = dz_q ? '1 : (neg_q ? -quo_mag : quo_mag);
  assign rem_fix  = rneg_q ? -rem_mag : rem_mag;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (start_md) state_d = ST_RUN;
      end
      ST_RUN:  if (cnt_q == '0) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix and HI/LO writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opd_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (xfer && op == OP_MTHI) hi <= a;
          if (xfer && op == OP_MTLO) lo <= a;
          if (start_md) begin
            cnt_q    <= SHW'(WIDTH - 1);
            acc_q    <= {{WIDTH{1'b0}}, mag_a};
            opd_q    <= mag_b;
            is_div_q <= (op == OP_DIV) || (op == OP_DIVU);
            neg_q    <= sgn_a ^ sgn_b;
            rneg_q   <= sgn_a;
            dz_q     <= (b == '0);
          end
        end
        ST_RUN: begin
          acc_q <= is_div_q ? div_next : mul_next;
          cnt_q <= cnt_q - SHW'(1);
        end
        ST_FIX: begin
          done <= 1'b1;
          if (is_div_q) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU: combinational integer ops plus sequential mul/div with HI/LO.
// Latency: C/Zero combinational; MULT/DIV WIDTH+1 edges; MTHI/MTLO one edge.
// Backpressure: in_ready low while mul/div runs; control unit holds the op.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] C,
  output logic             Zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] c_res;

  muldiv_seq #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .op       (op),
    .a        (A),
    .b        (B),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  // Result mux; independent of in_valid and sequencer state.
  always_comb begin
    c_res = '0;
    case (op)
      OP_NOP:  c_res = A;
      OP_ADD:  c_res = A + B;
      OP_SUB:  c_res = A - B;
      OP_AND:  c_res = A & B;
      OP_OR:   c_res = A | B;
      OP_NOR:  c_res = ~(A | B);
      OP_SLT:  c_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: c_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  c_res = B << shamt;
      OP_SRL:  c_res = B >> shamt;
      OP_SRA:  c_res = $signed(B) >>> shamt;
      OP_SLLV: c_res = B << A[SHW-1:0];
      OP_SRLV: c_res = B >> A[SHW-1:0];
      OP_SRAV: c_res = $signed(B) >>> A[SHW-1:0];
      OP_LUI:  c_res = B << (WIDTH / 2);
      OP_MFHI: c_res = hi;
      OP_MFLO: c_res = lo;
      default: c_res = '0;
    endcase
  end

  assign C    = c_res;
  assign Zero = (c_res == '0);

endmodule
